// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, LSB first, one bit every CLK_FREQ/BAUD cycles.
// Define UART_TX_PARITY_EN to send an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W   = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state, state_next;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift, shift_next;
    logic               push, pop, bit_end, fifo_empty;
    logic               txd_next, busy_next, done_next;
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    assign tx_ready   = (fifo_cnt != FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (baud_cnt == CNT_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && bit_idx == 3'd7) state_next = PARITY;
            PARITY: if (bit_end) state_next = STOP;
`else
            DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
`endif
            // Back-to-back frames: a queued byte goes straight from STOP into START.
            STOP:  if (bit_end) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        done_next  = 1'b0;
        txd_next   = 1'b1;
        shift_next = shift;
        case (state)
            IDLE: pop = !fifo_empty;
            DATA: if (bit_end) shift_next = {1'b0, shift[7:1]};
            STOP: begin
                done_next = bit_end;
                pop       = bit_end && !fifo_empty;
            end
            default: ;
        endcase
        if (pop) shift_next = fifo_mem[rd_ptr];
        // The line level is decided from the state being entered so uart_txd stays a plain flop.
        case (state_next)
            START:  txd_next = 1'b0;
            DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_next = parity;
`endif
            default: txd_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            uart_txd <= txd_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
            shift    <= shift_next;
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + CNT_W'(1);
            if (state != DATA)  bit_idx <= '0;
            else if (bit_end)   bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (pop) parity <= ^fifo_mem[rd_ptr];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx against a frame-timeline model and a line receiver, BAUD_DIV=10, FIFO_DEPTH=4.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;
    localparam int BD    = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic       clk, rst_n, tx_valid, tx_ready, uart_txd, tx_busy, tx_done;
    logic [7:0] tx_data;
    logic [2:0] fifo_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    bit started  = 0;

    logic       s_valid, s_rst;
    logic [7:0] s_data;
    logic [7:0] m_q[$];
    bit         m_active, m_done;
    int         m_pos;
    logic [7:0] m_cur;

    logic [7:0] rx_q[$];
    int         done_q[$];
    bit         rx_active;
    int         rx_t;
    logic [7:0] rx_byte;

    uart_tx #(.CLK_FREQ(125_000_000), .BAUD(12_500_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_txd(uart_txd), .tx_busy(tx_busy),
        .tx_done(tx_done), .fifo_cnt(fifo_cnt)
    );

    initial begin
        clk = 0;
        forever #4 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_valid <= tx_valid;
        s_data  <= tx_data;
        s_rst   <= rst_n;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a queue of bytes plus a position within the current frame; one call per clock edge.
    task automatic modelStep();
        bit ready_pre;
        m_done = 0;
        if (!rst_n || !s_rst) begin
            m_q.delete();
            m_active = 0;
            m_pos    = 0;
        end else begin
            ready_pre = (m_q.size() != DEPTH);
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_done = 1;
                    if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_pos = 0; end
                    else m_active = 0;
                end
            end else if (m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_active = 1; m_pos = 0;
            end
            if (s_valid && ready_pre) m_q.push_back(s_data);
        end
    endtask

    function automatic logic expTxd();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / BD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        @(negedge clk);
        if (started) begin
            modelStep();
            checkOutput("uart_txd", uart_txd, expTxd());
            checkOutput("tx_busy", tx_busy, m_active);
            checkOutput("tx_done", tx_done, m_done);
            checkOutput("fifo_cnt", fifo_cnt, m_q.size());
            checkOutput("tx_ready", tx_ready, m_q.size() != DEPTH);
            if (tx_done === 1'b1) done_q.push_back(cyc);
        end
    end

    // Line receiver: samples mid-bit and collects every frame that completes.
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) rx_active = 0;
        else if (!rx_active) begin
            if (uart_txd === 1'b0) begin rx_active = 1; rx_t = 0; rx_byte = 0; end
        end else begin
            rx_t++;
            if (rx_t % BD == 5 && rx_t / BD >= 1 && rx_t / BD <= 8) rx_byte[rx_t/BD-1] = uart_txd;
            if (rx_t == FRAME - 1) begin rx_q.push_back(rx_byte); rx_active = 0; end
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk); #1;
        tx_valid = 1; tx_data = d;
        @(negedge clk); #1;
        tx_valid = 0; tx_data = ~d;
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i > 2 && tx_busy === 1'b0 && fifo_cnt === 3'd0) break;
        end
        #1;
        checkOutput("drain_busy", tx_busy, 0);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic parityFrame(input logic [7:0] d, input logic par);
        applyStimulus(d);
        @(negedge clk);
        for (int t = 1; t <= FRAME; t++) begin
            @(negedge clk);
            if (t == 95)    checkOutput($sformatf("parity_%0h", d), uart_txd, par);
            if (t == 105)   checkOutput($sformatf("stop_%0h", d), uart_txd, 1);
            if (t == FRAME) checkOutput($sformatf("done110_%0h", d), tx_done, 1);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [9:0] lv;
        logic [7:0] b6 [6];
        int acc [6];
        int idx;
        bit rdy;

        rst_n = 1; tx_valid = 0; tx_data = 0;
        #2 rst_n = 0; started = 1;
        #1;
        checkOutput("rst_txd", uart_txd, 1);
        checkOutput("rst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1;

        repeat (200) @(negedge clk);
        #1;
        checkOutput("idle_txd", uart_txd, 1);
        checkOutput("idle_busy", tx_busy, 0);
        checkOutput("idle_cnt", fifo_cnt, 0);

        // Single byte 0x31: level of bit period i is lv[i].
        lv = 10'b1001100010;
        rx_q.delete(); done_q.delete();
        applyStimulus(8'h31);
        checkOutput("pre_start_txd", uart_txd, 1);
        @(negedge clk);
        checkOutput("start_latency", uart_txd, 0);
        for (int t = 1; t <= FRAME + 1; t++) begin
            @(negedge clk);
            if (t % BD == 5 && t / BD < 10) checkOutput($sformatf("bit%0d_31", t / BD), uart_txd, lv[t/BD]);
            if (t == FRAME - 1) checkOutput("done_early", tx_done, 0);
            if (t == FRAME) begin
                checkOutput("done_31", tx_done, 1);
                checkOutput("busy_after_31", tx_busy, 0);
            end
            if (t == FRAME + 1) checkOutput("done_width", tx_done, 0);
        end
        checkOutput("rx_31", rx_q.size() == 1 ? rx_q[0] : 8'hxx, 8'h31);

        // Two bytes on consecutive cycles: frames back to back.
        rx_q.delete(); done_q.delete();
        @(negedge clk); #1; tx_valid = 1; tx_data = 8'h55;
        @(negedge clk); #1; tx_data = 8'hA3;
        @(negedge clk); #1; tx_valid = 0; tx_data = 8'h00;
        waitIdle(3 * FRAME);
        checkOutput("b2b_done_count", done_q.size(), 2);
        if (done_q.size() == 2) checkOutput("b2b_done_gap", done_q[1] - done_q[0], FRAME);
        checkOutput("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            checkOutput("b2b_rx0", rx_q[0], 8'h55);
            checkOutput("b2b_rx1", rx_q[1], 8'hA3);
        end

        // Six bytes with tx_valid held: fills the FIFO, sixth waits for the first tx_done.
        b6 = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h7E, 8'h81};
        rx_q.delete(); done_q.delete();
        idx = 0;
        @(negedge clk); #1;
        for (int k = 0; k < 4 * FRAME && idx < 6; k++) begin
            tx_valid = 1; tx_data = b6[idx]; rdy = tx_ready;
            @(negedge clk); #1;
            if (rdy) begin
                acc[idx] = cyc;
                idx++;
                if (idx == 5) begin
                    checkOutput("full_cnt", fifo_cnt, 4);
                    checkOutput("full_ready", tx_ready, 0);
                end
            end
        end
        tx_valid = 0; tx_data = 8'h00;
        checkOutput("burst_all_accepted", idx, 6);
        if (idx == 6) begin
            checkOutput("burst_consecutive", acc[4] - acc[0], 4);
            if (done_q.size() > 0) checkOutput("byte6_after_done", acc[5], done_q[0] + 1);
        end
        waitIdle(7 * FRAME);
        checkOutput("burst_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            checkOutput($sformatf("burst_rx%0d", i), rx_q[i], b6[i]);

        // Reset mid-DATA of 0xF0 with two bytes queued.
        rx_q.delete(); done_q.delete();
        @(negedge clk); #1; tx_valid = 1; tx_data = 8'hF0;
        @(negedge clk); #1; tx_data = 8'h11;
        @(negedge clk); #1; tx_data = 8'h22;
        @(negedge clk); #1; tx_valid = 0; tx_data = 8'h00;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("pre_rst_busy", tx_busy, 1);
        checkOutput("pre_rst_cnt", fifo_cnt, 2);
        rst_n = 0;
        #1;
        checkOutput("midrst_txd", uart_txd, 1);
        checkOutput("midrst_cnt", fifo_cnt, 0);
        checkOutput("midrst_busy", tx_busy, 0);
        checkOutput("midrst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        repeat (200) @(negedge clk);
        #1;
        checkOutput("postrst_rx", rx_q.size(), 0);
        checkOutput("postrst_done", done_q.size(), 0);
        checkOutput("postrst_txd", uart_txd, 1);

`ifdef UART_TX_PARITY_EN
        parityFrame(8'h31, 1'b1);
        parityFrame(8'h33, 1'b0);
        waitIdle(FRAME);
`endif

        $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
